io_port_controller: RTL
=======================

# io_port_controller

Peripheral port bank that sits directly downstream of the command-controlled device's port bus. It decodes `port_id`/`port_read`/`port_write`, latches write data into output ports, and returns read data for the device's `data_in`. Read data comes from synchronized input pins, a status register, or a small receive FIFO filled by an external strobe-driven producer.

## Interface
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2, flip-flop stages on each asynchronous input pin; at least 2.

- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `port_id`  in  3  port address from the device.
- `port_read`  in  1  read strobe, one cycle per access.
- `port_write`  in  1  write strobe, one cycle per access.
- `wr_data`  in  4  write data (the device's `data_out`).
- `rd_data`  out  4  read data (to the device's `data_in`).
- `out_ports`  out  16  four 4-bit output latches; port k occupies bits [4k+3:4k].
- `in_port_a`  in  4  asynchronous external pins.
- `in_port_b`  in  4  asynchronous external pins.
- `rx_data`  in  4  receive data, valid while `rx_strobe` is high.
- `rx_strobe`  in  1  single-cycle push request; there is no backpressure.
- `irq`  out  1  high while the FIFO is non-empty or any sticky status bit is set.

## Operation
- **Port map:**
  - Ports 0–3: output latches. A write loads `wr_data`; a read returns the latch value.
  - Port 4: synchronized `in_port_a`. Port 5: synchronized `in_port_b`. Writes to 4 and 5 are ignored.
  - Port 6: status.
  - Port 7: FIFO head; a read pops the entry.
- **Status word:**
  - bit3: overflow (sticky).
  - bit2: full.
  - bit1: empty.
  - bit0: a_changed (sticky). It sets when the synchronized `in_port_a` differs from its value on the previous cycle.
  - A write to port 6 is write-1-to-clear on bits 3 and 0; bits 2 and 1 ignore writes.
- **`rd_data`:** combinational. It equals the addressed value while `port_read` = 1, else 4'h0.
- **Empty FIFO read:** a read of port 7 returns 4'h0 and changes no state.
- **Push:** `rx_strobe` with the FIFO not full writes `rx_data` at the tail.
  - `rx_strobe` while full with no pop in the same cycle drops the data and sets overflow.
  - Push and pop in the same cycle while full: both happen, occupancy is unchanged, and overflow does not set.
  - Push and pop in the same cycle while empty: the push happens, `rd_data` = 4'h0, and occupancy becomes 1.
- **Pointers:** read and write pointers wrap modulo `FIFO_DEPTH`. Occupancy is a counter of width clog2(`FIFO_DEPTH`)+1.
- **Write conflicts:** a sticky set event in the same cycle as its clear-write leaves the bit set (set wins).
- **Simultaneous strobes:** `port_read` and `port_write` high together are both processed independently; the read value is the pre-edge state.
- **Reset values:**
  - `out_ports` = 16'h0.
  - FIFO empty (empty = 1, full = 0), pointers 0.
  - overflow = 0, a_changed = 0, `irq` = 0.
  - Synchronizer chains and the previous-sample register all 0.
  - `rd_data` follows its combinational rule.
- **Reset mid-operation:** FIFO contents are discarded. The first cycle after release behaves as power-up; no spurious a_changed is allowed, because the previous-sample register also resets to 0.

## Timing
- Output latch: written on the edge where `port_write` = 1; visible on `out_ports` after that edge (1-cycle latency).
- Input pins: `SYNC_STAGES` cycles from pin change to its visibility at port 4/5. a_changed sets on the following edge.
- FIFO: a pushed entry is readable at port 7 on the cycle after the push edge. A pop takes effect on the edge ending the read cycle.
- `irq`: registered; it reflects state after each edge.
- Status full/empty: combinational from the occupancy register.

## Structure
- Shared package `io_port_pkg`:
  - port address constants `PORT_OUT0..PORT_OUT3`, `PORT_IN_A`, `PORT_IN_B`, `PORT_STATUS`, `PORT_RX`;
  - status bit indices `ST_OVF`, `ST_FULL`, `ST_EMPTY`, `ST_ACHG`.
- One sub-module, `rx_fifo`:
  - parameterized by `FIFO_DEPTH`;
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `overflow_evt`.
- Decode, latches, synchronizers and status logic stay in the top module.

## Test plan
- **Output latch:** write 4'hA to port 2 → `out_ports`[11:8] = 4'hA next cycle; read port 2 returns 4'hA; other latches remain 0.
- **Input synchronizer:** `in_port_a` 0→4'h5 → port 4 reads 4'h5 no earlier than 2 cycles later; status bit0 = 1 and `irq` = 1; write 4'h1 to port 6 → bit0 = 0.
- **FIFO order and empty read:** push 3,7,9 → three reads of port 7 return 3,7,9 in order; a fourth read returns 0 with status empty = 1.
- **Overflow:** push 4 entries, then one more → status = 4'b1100 (overflow, full); contents 1st–4th intact. Repeat with a pop in the same cycle as the 5th push → no overflow, and the 5th value is last out.
- **Reset mid-operation:** drive `reset` low mid-stream with FIFO holding 2 entries and `out_ports` = 16'hFFFF → immediately `out_ports` = 0, `irq` = 0; after release, status reads 4'b0010.

Source files
------------

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the io_port_controller slice.
//   Port addresses decoded from port_id, and bit positions in the status word.
package io_port_pkg;

  localparam logic [2:0] PORT_OUT0   = 3'd0;
  localparam logic [2:0] PORT_OUT1   = 3'd1;
  localparam logic [2:0] PORT_OUT2   = 3'd2;
  localparam logic [2:0] PORT_OUT3   = 3'd3;
  localparam logic [2:0] PORT_IN_A   = 3'd4;
  localparam logic [2:0] PORT_IN_B   = 3'd5;
  localparam logic [2:0] PORT_STATUS = 3'd6;
  localparam logic [2:0] PORT_RX     = 3'd7;

  localparam int unsigned ST_OVF   = 3;
  localparam int unsigned ST_FULL  = 2;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_ACHG  = 0;

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: small receive FIFO of 4-bit entries.
//   clock, reset      : system clock, async active-low reset (clears pointers/occupancy)
//   push, din         : write request and data; no backpressure
//   pop, dout         : read request and head entry (dout only meaningful when !empty)
//   full, empty       : decoded from the occupancy counter
//   overflow_evt      : push attempted while full with no simultaneous pop
module rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty,
  output logic       overflow_evt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [3:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop on an empty FIFO is ignored; a pop frees a slot for a same-cycle
  // push when full, so that push is accepted and no overflow is flagged.
  assign do_pop       = pop & ~empty;
  assign do_push      = push & (~full | do_pop);
  assign overflow_evt = push & full & ~do_pop;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// io_port_controller: port bank behind the device's port bus.
//   clock, reset            : system clock, async active-low reset
//   port_id/read/write      : bus address and one-cycle strobes
//   wr_data / rd_data       : write data in, combinational read data out
//   out_ports               : four 4-bit output latches (port k at [4k+3:4k])
//   in_port_a, in_port_b    : asynchronous pins, synchronized before use
//   rx_data, rx_strobe      : receive FIFO producer interface
//   irq                     : FIFO non-empty or any sticky status bit set
module io_port_controller
  import io_port_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  port_id,
  input  logic        port_read,
  input  logic        port_write,
  input  logic [3:0]  wr_data,
  output logic [3:0]  rd_data,
  output logic [15:0] out_ports,
  input  logic [3:0]  in_port_a,
  input  logic [3:0]  in_port_b,
  input  logic [3:0]  rx_data,
  input  logic        rx_strobe,
  output logic        irq
);

  logic [3:0][3:0]             out_q;
  logic [SYNC_STAGES-1:0][3:0] sync_a, sync_b;
  logic [3:0]                  sync_a_q, sync_b_q, prev_a;
  logic                        ovf_q, achg_q;
  logic                        ovf_evt, achg_evt, st_clr;
  logic                        fifo_full, fifo_empty, fifo_pop;
  logic [3:0]                  fifo_dout;
  logic [3:0]                  status;

  assign out_ports = out_q;
  assign sync_a_q  = sync_a[SYNC_STAGES-1];
  assign sync_b_q  = sync_b[SYNC_STAGES-1];
  assign fifo_pop  = port_read & (port_id == PORT_RX);
  assign st_clr    = port_write & (port_id == PORT_STATUS);
  assign achg_evt  = (sync_a_q != prev_a);

  rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (rx_strobe),
    .pop          (fifo_pop),
    .din          (rx_data),
    .dout         (fifo_dout),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .overflow_evt (ovf_evt)
  );

  always_comb begin
    status           = '0;
    status[ST_OVF]   = ovf_q;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_ACHG]  = achg_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      sync_a <= '0;
      sync_b <= '0;
      prev_a <= '0;
      ovf_q  <= 1'b0;
      achg_q <= 1'b0;
    end else begin
      if (port_write && !port_id[2]) out_q[port_id[1:0]] <= wr_data;
      sync_a <= {sync_a[SYNC_STAGES-2:0], in_port_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], in_port_b};
      prev_a <= sync_a_q;
      // Set wins over a write-1-to-clear landing in the same cycle.
      ovf_q  <= ovf_evt  | (ovf_q  & ~(st_clr & wr_data[ST_OVF]));
      achg_q <= achg_evt | (achg_q & ~(st_clr & wr_data[ST_ACHG]));
    end
  end

  // Every term is a flop output (occupancy counter, sticky bits), so irq
  // tracks post-edge state and drops immediately with reset.
  assign irq = ~fifo_empty | ovf_q | achg_q;

  always_comb begin
    rd_data = '0;
    if (port_read) begin
      case (port_id)
        PORT_OUT0, PORT_OUT1,
        PORT_OUT2, PORT_OUT3: rd_data = out_q[port_id[1:0]];
        PORT_IN_A:            rd_data = sync_a_q;
        PORT_IN_B:            rd_data = sync_b_q;
        PORT_STATUS:          rd_data = status;
        PORT_RX:              rd_data = fifo_empty ? 4'h0 : fifo_dout;
        default:              rd_data = '0;
      endcase
    end
  end

endmodule
